// File: rtl/pi_link_arbiter.sv
// pi_link_arbiter: shares the Pi serial link between ZX memory-read, IO-read and IO-write requesters and receives Pi commands.
// Optional abort of stalled transactions when LINK_TIMEOUT_EN is defined.
module pi_link_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W = 13
) (
  input  logic        PI_MASTER_CLK,
  input  logic        RST_N,
  input  logic        mem_req,
  input  logic [15:0] mem_addr,
  input  logic        io_rd_req,
  input  logic        io_wr_req,
  input  logic [15:0] io_addr,
  input  logic [7:0]  io_wdata,
  output logic [2:0]  ack,
  output logic [7:0]  rdata,
  output logic        zx_wait_n,
  output logic        busy,
  output logic        cmd_valid,
  output logic [3:0]  cmd_data,
  input  logic        pi_io_clk,
  input  logic        pi_mosi,
  input  logic        pi_io_in,
  output logic        pi_io_out,
  output logic        pi_io_oe,
  output logic        pi_miso
);
  typedef enum logic [2:0] {IDLE, TX, TURN, RX, DONE, CMD_RX} state_t;
  state_t state, nxt;
  logic [2:0] clk_s, mosi_s;
  logic [1:0] io_s;
  logic [1:0] sel, gsel;
  logic [25:0] shreg, frame;
  logic [4:0] bitcnt;
  logic [7:0] rx;
  logic [3:0] cmd_sh;
  logic rise, mosi_hi, mosi_rise, mosi_fall, req_any, last, tmo;
  if (TIMEOUT_CYCLES >= 2 ** TIMEOUT_W) begin : g_width_check
    $error("TIMEOUT_W cannot hold TIMEOUT_CYCLES");
  end
  assign rise = clk_s[1] & ~clk_s[2];
  assign mosi_hi = mosi_s[1];
  assign mosi_rise = mosi_s[1] & ~mosi_s[2];
  assign mosi_fall = ~mosi_s[1] & mosi_s[2];
  assign req_any = mem_req | io_rd_req | io_wr_req;
  assign gsel = mem_req ? 2'd0 : io_rd_req ? 2'd1 : 2'd2;
  // Frames are left-aligned so the MSB is always shreg[25]; reads pad the tail.
  assign frame = (gsel == 2'd2) ? {2'b10, io_addr, io_wdata} :
                 (gsel == 2'd1) ? {2'b01, io_addr, 8'h00} : {2'b00, mem_addr, 8'h00};
  assign last = bitcnt == ((sel == 2'd2) ? 5'd25 : 5'd17);
  assign ack = (state == DONE) ? (3'b001 << sel) : 3'b000;
  assign zx_wait_n = ~req_any | (|ack);
  assign busy = state != IDLE;
  assign pi_io_out = shreg[25];
`ifdef LINK_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt;
  always_ff @(posedge PI_MASTER_CLK or negedge RST_N)
    if (!RST_N) tcnt <= '0;
    else tcnt <= (state == IDLE) ? '0 : (state == TX || state == TURN || state == RX) ? tcnt + 1'b1 : tcnt;
  assign tmo = tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge PI_MASTER_CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = mosi_hi ? CMD_RX : req_any ? TX : IDLE;
      TX:      nxt = tmo ? DONE : (rise && last) ? ((sel == 2'd2) ? DONE : TURN) : TX;
      TURN:    nxt = tmo ? DONE : mosi_rise ? RX : TURN;
      RX:      nxt = (tmo || mosi_fall) ? DONE : RX;
      DONE:    nxt = IDLE;
      CMD_RX:  nxt = mosi_fall ? IDLE : CMD_RX;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge PI_MASTER_CLK or negedge RST_N)
    if (!RST_N) begin
      clk_s <= '0;
      mosi_s <= '0;
      io_s <= '0;
      sel <= '0;
      shreg <= '0;
      bitcnt <= '0;
      rx <= '0;
      cmd_sh <= '0;
      rdata <= 8'h00;
      cmd_valid <= 1'b0;
      cmd_data <= '0;
      pi_io_oe <= 1'b0;
      pi_miso <= 1'b0;
    end else begin
      clk_s <= {clk_s[1:0], pi_io_clk};
      mosi_s <= {mosi_s[1:0], pi_mosi};
      io_s <= {io_s[0], pi_io_in};
      cmd_valid <= 1'b0;
      case (state)
        IDLE: begin
          bitcnt <= '0;
          if (!mosi_hi && req_any) begin
            sel <= gsel;
            shreg <= frame;
            pi_miso <= 1'b1;
            pi_io_oe <= 1'b1;
          end
        end
        TX:
          if (tmo) begin
            pi_miso <= 1'b0;
            pi_io_oe <= 1'b0;
            if (sel != 2'd2) rdata <= 8'hFF;
          end else if (rise) begin
            shreg <= {shreg[24:0], 1'b0};
            bitcnt <= bitcnt + 5'd1;
            if (last) begin
              pi_miso <= 1'b0;
              pi_io_oe <= 1'b0;
            end
          end
        TURN:
          if (tmo) rdata <= 8'hFF;
          else if (mosi_rise) bitcnt <= '0;
        RX:
          if (tmo) rdata <= 8'hFF;
          else begin
            if (rise && bitcnt < 5'd8) begin
              rx <= {rx[6:0], io_s[1]};
              bitcnt <= bitcnt + 5'd1;
            end
            if (mosi_fall) rdata <= (bitcnt == 5'd8) ? rx : 8'hFF;
          end
        CMD_RX: begin
          // Saturating at 5 is enough to tell "exactly four" from "more".
          if (rise && bitcnt < 5'd5) begin
            cmd_sh <= {cmd_sh[2:0], io_s[1]};
            bitcnt <= bitcnt + 5'd1;
          end
          if (mosi_fall && bitcnt == 5'd4) begin
            cmd_valid <= 1'b1;
            cmd_data <= cmd_sh;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_pi_link_arbiter.sv
// tb_pi_link_arbiter: Pi-side model drives the link; a scoreboard monitor checks every ack and command pulse.
module tb_pi_link_arbiter;
  logic clk = 0, rst_n = 0;
  logic mem_req = 0, io_rd_req = 0, io_wr_req = 0;
  logic [15:0] mem_addr = 0, io_addr = 0;
  logic [7:0] io_wdata = 0, rdata;
  logic [2:0] ack, prev_ack = 0;
  logic zx_wait_n, busy, cmd_valid, pi_io_out, pi_io_oe, pi_miso;
  logic [3:0] cmd_data;
  logic pi_io_clk = 0, pi_mosi = 0, pi_io_in = 0;
  typedef struct packed {logic [2:0] a; logic [7:0] d; logic rd;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [3:0] cmd_q[$];
  int n_chk = 0, n_pass = 0, acks_seen = 0, cmd_seen = 0, want = 0;

  pi_link_arbiter #(.TIMEOUT_CYCLES(64), .TIMEOUT_W(13)) dut (
    .PI_MASTER_CLK(clk), .RST_N(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .io_rd_req(io_rd_req), .io_wr_req(io_wr_req), .io_addr(io_addr), .io_wdata(io_wdata),
    .ack(ack), .rdata(rdata), .zx_wait_n(zx_wait_n), .busy(busy), .cmd_valid(cmd_valid),
    .cmd_data(cmd_data), .pi_io_clk(pi_io_clk), .pi_mosi(pi_mosi), .pi_io_in(pi_io_in),
    .pi_io_out(pi_io_out), .pi_io_oe(pi_io_oe), .pi_miso(pi_miso));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  initial forever begin
    @(negedge clk);
    if (prev_ack != 0) chk("ack_one_cycle", 32'(ack), 0);
    prev_ack = ack;
    if (ack != 0) begin
      chk("wait_released", 32'(zx_wait_n), 1);
      if (exp_q.size() == 0) chk("unexpected_ack", 32'(ack), 0);
      else begin
        e = exp_q.pop_front();
        chk("ack", 32'(ack), 32'(e.a));
        if (e.rd) chk("rdata", 32'(rdata), 32'(e.d));
      end
    end
    if (cmd_valid) begin
      cmd_seen++;
      if (cmd_q.size() == 0) chk("unexpected_cmd", 32'(cmd_valid), 0);
      else chk("cmd_data", 32'(cmd_data), 32'(cmd_q.pop_front()));
    end
  end

  task automatic tick;
    @(negedge clk);
    if (ack[0]) mem_req = 0;
    if (ack[1]) io_rd_req = 0;
    if (ack[2]) io_wr_req = 0;
    if (ack != 0) acks_seen++;
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic pi_edge(input logic d);
    pi_io_in = d;
    pi_io_clk = 1;
    ticks(4);
    pi_io_clk = 0;
    ticks(4);
  endtask
  task automatic pi_read(input int n, output logic [25:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = {v[24:0], pi_io_out};
      pi_edge(1'b0);
    end
  endtask
  task automatic pi_reply(input int n, input logic [7:0] d);
    pi_mosi = 1;
    ticks(4);
    for (int i = 0; i < n; i++) pi_edge(d[7-i]);
    pi_mosi = 0;
  endtask
  task automatic wait_miso;
    int k = 0;
    while (!pi_miso && k < 200) begin tick(); k++; end
    chk("miso_rise", 32'(pi_miso), 1);
  endtask
  task automatic wait_acks(input int target);
    int k = 0;
    while (acks_seen < target && k < 400) begin tick(); k++; end
    chk("ack_seen", acks_seen, target);
  endtask
  task automatic expect_ack(input logic [2:0] a, input logic [7:0] d, input logic rd);
    exp_q.push_back({a, d, rd});
    want++;
  endtask
  task automatic chk_reset_outputs;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_wait_n", 32'(zx_wait_n), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_data", 32'(cmd_data), 0);
    chk("rst_io_out", 32'(pi_io_out), 0);
    chk("rst_io_oe", 32'(pi_io_oe), 0);
    chk("rst_miso", 32'(pi_miso), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] v, w;
    int n;
    ticks(3);
    chk_reset_outputs();
    rst_n = 1;
    ticks(2);
    // memory read of address 0, Pi answers 0xCD
    mem_addr = 16'h0000; mem_req = 1;
    expect_ack(3'b001, 8'hCD, 1);
    wait_miso();
    chk("tx_oe", 32'(pi_io_oe), 1);
    pi_read(18, v);
    chk("mem_frame", 32'(v), 32'({2'b00, 16'h0000}));
    chk("turn_miso", 32'(pi_miso), 0);
    chk("turn_oe", 32'(pi_io_oe), 0);
    pi_reply(8, 8'b11001101);
    wait_acks(want);
    tick();
    chk("wait_n_idle", 32'(zx_wait_n), 1);
    // IO write, 26-bit frame, no MOSI phase
    io_addr = 16'hFE1F; io_wdata = 8'h5A; io_wr_req = 1;
    expect_ack(3'b100, 8'h00, 0);
    wait_miso();
    pi_read(25, v);
    chk("miso_before_last", 32'(pi_miso), 1);
    pi_read(1, w);
    v = {v[24:0], w[0]};
    chk("wr_frame", 32'(v), 32'({2'b10, 16'hFE1F, 8'h5A}));
    chk("wr_miso_low", 32'(pi_miso), 0);
    wait_acks(want);
    // simultaneous mem and io read: mem first, then io read after one idle cycle
    mem_addr = 16'h8001; io_addr = 16'hBF3E; mem_req = 1; io_rd_req = 1;
    expect_ack(3'b001, 8'hA5, 1);
    expect_ack(3'b010, 8'h3C, 1);
    wait_miso();
    pi_read(18, v);
    chk("prio_frame", 32'(v), 32'({2'b00, 16'h8001}));
    pi_reply(8, 8'hA5);
    wait_acks(want - 1);
    tick();
    chk("gap_idle", 32'(busy), 0);
    tick();
    chk("gap_regrant", 32'(pi_miso), 1);
    pi_read(18, v);
    chk("iord_frame", 32'(v), 32'({2'b01, 16'hBF3E}));
    pi_reply(8, 8'h3C);
    wait_acks(want);
    // Pi command wins against a same-cycle io read
    io_addr = 16'h1234;
    pi_mosi = 1;
    ticks(2);
    io_rd_req = 1;
    cmd_q.push_back(4'h3);
    expect_ack(3'b010, 8'h96, 1);
    ticks(4);
    chk("cmd_busy", 32'(busy), 1);
    chk("cmd_no_tx", 32'(pi_miso), 0);
    chk("cmd_no_oe", 32'(pi_io_oe), 0);
    pi_edge(0); pi_edge(0); pi_edge(1); pi_edge(1);
    pi_mosi = 0;
    ticks(6);
    chk("cmd_seen", cmd_seen, 1);
    wait_miso();
    pi_read(18, v);
    chk("after_cmd_frame", 32'(v), 32'({2'b01, 16'h1234}));
    pi_reply(8, 8'h96);
    wait_acks(want);
    // three-bit command is discarded
    pi_mosi = 1;
    ticks(4);
    pi_edge(0); pi_edge(1); pi_edge(1);
    pi_mosi = 0;
    ticks(8);
    chk("cmd_3bit_dropped", cmd_seen, 1);
    chk("cmd_3bit_idle", 32'(busy), 0);
    // short RX phase yields 0xFF
    io_addr = 16'h0042; io_rd_req = 1;
    expect_ack(3'b010, 8'hFF, 1);
    wait_miso();
    pi_read(18, v);
    chk("short_frame", 32'(v), 32'({2'b01, 16'h0042}));
    pi_reply(6, 8'h12);
    wait_acks(want);
    // reset mid-TX, then the re-raised request is served
    mem_addr = 16'hFFFF; mem_req = 1;
    wait_miso();
    pi_read(5, v);
    chk("tx_mid_out", 32'(pi_io_out), 1);
    rst_n = 0; mem_req = 0;
    #1;
    chk_reset_outputs();
    ticks(2);
    rst_n = 1;
    tick();
    mem_req = 1;
    expect_ack(3'b001, 8'h7E, 1);
    wait_miso();
    pi_read(18, v);
    chk("post_rst_frame", 32'(v), 32'({2'b00, 16'hFFFF}));
    pi_reply(8, 8'h7E);
    wait_acks(want);
`ifdef LINK_TIMEOUT_EN
    // stalled Pi: abort 64 cycles after grant
    io_addr = 16'h0001; io_rd_req = 1;
    expect_ack(3'b010, 8'hFF, 1);
    wait_miso();
    n = 1;
    tick();
    while (ack == 0 && n < 200) begin tick(); n++; end
    chk("tmo_cycles", n, 64);
    chk("tmo_miso", 32'(pi_miso), 0);
    wait_acks(want);
`else
    n = 0;
`endif
    ticks(5);
    chk("scoreboard_empty", exp_q.size() + cmd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
